// File: rtl/key_pkg.sv
// Shared definitions for the key event decoder: FSM state encoding and timer width.
package key_pkg;

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } key_state_t;

endpackage

// File: rtl/key_event_decoder_evt_timer.sv
// Clearable saturating cycle counter that flags when it equals a terminal-count value.
module evt_timer
    import key_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_tc,
    output logic             o_hit
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == i_tc);

endmodule

// File: rtl/key_event_decoder.sv
// Turns debounced press/release pulses into short, double, long and hold-repeat events.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int unsigned LONG_TIME   = 27_000_000,
    parameter int unsigned DCLICK_GAP  = 8_100_000,
    parameter int unsigned REPEAT_TIME = 5_400_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flag_press,
    input  logic flag_release,
    output logic short_click,
    output logic double_click,
    output logic long_press,
    output logic hold_repeat,
    output logic key_down
);

    localparam logic [CNT_W-1:0] TC_LONG   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] TC_DCLICK = CNT_W'(DCLICK_GAP - 1);
    localparam logic [CNT_W-1:0] TC_REPEAT = CNT_W'(REPEAT_TIME - 1);

    key_state_t       r_state, w_next;
    logic [CNT_W-1:0] w_tc;
    logic             w_hit, w_clr;
    logic             w_press, w_release;
    logic             w_short, w_double, w_long, w_repeat, w_key_down;
    logic             r_short, r_double, r_long, r_repeat, r_key_down;

    // Simultaneous press and release cancel each other out.
    assign w_press   = flag_press & ~flag_release;
    assign w_release = flag_release & ~flag_press;

    evt_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_tc  (w_tc),
        .o_hit (w_hit)
    );

    always_comb begin
        w_next   = r_state;
        w_tc     = CNT_MAX;
        w_short  = 1'b0;
        w_double = 1'b0;
        w_long   = 1'b0;
        w_repeat = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) w_next = ST_PRESS1;
            end
            ST_PRESS1: begin
                w_tc = TC_LONG;
                if (w_release) begin
                    w_next = ST_WAIT2;
                end else if (w_hit) begin
                    w_next = ST_LONG;
                    w_long = 1'b1;
                end
            end
            ST_WAIT2: begin
                w_tc = TC_DCLICK;
                if (w_press) begin
                    w_next = ST_PRESS2;
                end else if (w_hit) begin
                    w_next  = ST_IDLE;
                    w_short = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (w_release) begin
                    w_next   = ST_IDLE;
                    w_double = 1'b1;
                end
            end
            ST_LONG: begin
                w_tc = TC_REPEAT;
                if (w_release) begin
                    w_next = ST_IDLE;
                end else if (w_hit) begin
                    w_repeat = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // A repeat pulse restarts the interval just like a state change does.
        w_clr      = (w_next != r_state) || w_repeat;
        w_key_down = (w_next == ST_PRESS1) || (w_next == ST_PRESS2) || (w_next == ST_LONG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_short    <= 1'b0;
            r_double   <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
            r_key_down <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_short    <= w_short;
            r_double   <= w_double;
            r_long     <= w_long;
            r_repeat   <= w_repeat;
            r_key_down <= w_key_down;
        end
    end

    assign short_click  = r_short;
    assign double_click = r_double;
    assign long_press   = r_long;
    assign hold_repeat  = r_repeat;
    assign key_down     = r_key_down;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_TIME=10, DCLICK_GAP=6, REPEAT_TIME=4.
module tb_key_event_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flag_press = 1'b0;
    logic flag_release = 1'b0;
    logic short_click, double_click, long_press, hold_repeat, key_down;

    int n_chk = 0;
    int n_fail = 0;

    key_event_decoder #(
        .LONG_TIME   (10),
        .DCLICK_GAP  (6),
        .REPEAT_TIME (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flag_press   (flag_press),
        .flag_release (flag_release),
        .short_click  (short_click),
        .double_click (double_click),
        .long_press   (long_press),
        .hold_repeat  (hold_repeat),
        .key_down     (key_down)
    );

    always #5 clk = ~clk;

    // Bit c of pm/rm drives flag_press/flag_release during scenario cycle c.
    typedef struct {
        string       name;
        logic [31:0] pm;
        logic [31:0] rm;
        int          len;
        int          e_short;
        int          e_dbl;
        int          e_long;
        int          rep0;
        int          rep_hi;
        int          kd_lo1;
        int          kd_hi1;
        int          kd_lo2;
        int          kd_hi2;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string nm, input int cyc, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", nm, cyc, got, exp);
        end
    endtask

    task automatic check_all(input string nm, input int cyc, input logic es, input logic ed,
                             input logic el, input logic er, input logic ek);
        check({nm, ".short_click"},  cyc, short_click,  es);
        check({nm, ".double_click"}, cyc, double_click, ed);
        check({nm, ".long_press"},   cyc, long_press,   el);
        check({nm, ".hold_repeat"},  cyc, hold_repeat,  er);
        check({nm, ".key_down"},     cyc, key_down,     ek);
    endtask

    task automatic step(input logic p, input logic r);
        @(posedge clk);
        #1;
        flag_press   = p;
        flag_release = r;
    endtask

    task automatic run_vec(input vec_t v);
        logic ek, er;
        for (int c = 0; c < v.len; c++) begin
            step(v.pm[c], v.rm[c]);
            @(negedge clk);
            ek = ((c >= v.kd_lo1) && (c <= v.kd_hi1)) || ((c >= v.kd_lo2) && (c <= v.kd_hi2));
            er = (v.rep0 >= 0) && (c >= v.rep0) && (c <= v.rep_hi) && (((c - v.rep0) % 4) == 0);
            check_all(v.name, c, c == v.e_short, c == v.e_dbl, c == v.e_long, er, ek);
        end
    endtask

    initial begin
        vt[0] = '{"short",       32'h0000_0001, 32'h0000_0008, 14, 10, -1, -1, -1, -1, 1, 3, 1, 0};
        vt[1] = '{"double",      32'h0000_0041, 32'h0000_0108, 20, -1,  9, -1, -1, -1, 1, 3, 7, 8};
        vt[2] = '{"long",        32'h0000_2001, 32'h0200_0000, 30, -1, -1, 11, 15, 23, 1, 25, 1, 0};
        vt[3] = '{"wait2_edge",  32'h0000_0201, 32'h0000_0808, 16, -1, 12, -1, -1, -1, 1, 3, 10, 11};
        vt[4] = '{"both_idle",   32'h0000_0004, 32'h0000_0004,  6, -1, -1, -1, -1, -1, 1, 0, 1, 0};
        vt[5] = '{"both_press1", 32'h0000_0009, 32'h0000_0028, 16, 12, -1, -1, -1, -1, 1, 5, 1, 0};
        vt[6] = '{"ignored",     32'h0000_0005, 32'h0000_0028, 14, 10, -1, -1, -1, -1, 1, 3, 1, 0};
        vt[7] = '{"press2_hold", 32'h0000_0021, 32'h0010_0008, 24, -1, 21, -1, -1, -1, 1, 3, 6, 20};
        vt[8] = '{"rel_vs_tout", 32'h0000_0001, 32'h0000_0400, 20, 17, -1, -1, -1, -1, 1, 10, 1, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(vt[i]);
        end

        // Reset while key is held must clear key_down without waiting for a clock edge.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk);
        check("rst_press1.key_down_before", 1, key_down, 1'b1);
        step(1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_all("rst_press1_async", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            check_all("rst_press1_after", c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset in the double-click window must drop the pending short click.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_all("rst_wait2_async", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_all("rst_wait2_after", c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_TIME, default 27_000_000, meaning clk cycles a press must be held to count as long press.
REQ-002 SHALL have parameter DCLICK_GAP, default 8_100_000, meaning clk cycles after release to wait for a second press.
REQ-003 SHALL have parameter REPEAT_TIME, default 5_400_000, meaning clk cycles between hold-repeat pulses during a long press.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flag_press  input  1  one-cycle debounced key-press pulse.
REQ-007 SHALL have port flag_release  input  1  one-cycle debounced key-release pulse.
REQ-008 SHALL have port short_click  output  1  one-cycle pulse for a single short click.
REQ-009 SHALL have port double_click  output  1  one-cycle pulse for two clicks within DCLICK_GAP.
REQ-010 SHALL have port long_press  output  1  one-cycle pulse when hold reaches LONG_TIME.
REQ-011 SHALL have port hold_repeat  output  1  one-cycle pulse every REPEAT_TIME while long-held.
REQ-012 SHALL have port key_down  output  1  level, high while state is PRESS1, PRESS2 or LONG.

Function
REQ-013 SHALL implement FSM states IDLE, PRESS1, WAIT2, PRESS2, LONG, plus a 32-bit cycle counter cnt cleared on every state change and incremented every cycle otherwise, saturating at all-ones.
REQ-014 SHALL, in IDLE on flag_press, go to PRESS1; flag_release in IDLE is ignored.
REQ-015 SHALL, in PRESS1 on flag_release, go to WAIT2; else when cnt == LONG_TIME-1, go to LONG and pulse long_press.
REQ-016 SHALL, in WAIT2 on flag_press, go to PRESS2; else when cnt == DCLICK_GAP-1, go to IDLE and pulse short_click.
REQ-017 SHALL, in PRESS2 on flag_release, go to IDLE and pulse double_click, regardless of hold duration (no long_press from PRESS2).
REQ-018 SHALL, in LONG, pulse hold_repeat each time cnt == REPEAT_TIME-1 and then restart cnt at 0; on flag_release go to IDLE with no further pulse.
REQ-019 SHALL register all outputs: pulse asserted for exactly one cycle, the cycle after the triggering condition is sampled.
REQ-020 SHALL give input events priority over a timeout sampled in the same cycle.
REQ-021 SHALL treat flag_press and flag_release asserted in the same cycle as no event.
REQ-022 SHALL ignore flag_press in PRESS1, PRESS2, LONG and flag_release in WAIT2.
REQ-023 SHALL assert at most one of short_click, double_click, long_press, hold_repeat in any cycle.
REQ-024 SHALL return any undefined state encoding to IDLE on the next clock.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force state IDLE, cnt 0, and all five outputs 0.
REQ-026 SHALL discard any in-progress click sequence on reset mid-operation; no pulse emitted after reset deassertion until a new flag_press.

Structure
REQ-027 SHALL place state encodings (3-bit) and the counter width constant in shared package key_pkg.
REQ-028 SHALL use one sub-module evt_timer: 32-bit clearable saturating counter with terminal-count compare input.
REQ-029 SHALL keep implementation within 120-400 lines of RTL.

Verification (LONG_TIME=10, DCLICK_GAP=6, REPEAT_TIME=4)
REQ-030 SHALL cover: press at t0, release at t0+3 (cycle t1) -> short_click high only at t1+7; no other pulses.
REQ-031 SHALL cover: press t0, release t0+3, press t0+6, release t0+8 -> double_click high only at t0+9; no short_click.
REQ-032 SHALL cover: press t0, held 25 cycles -> long_press at t0+11, hold_repeat at t0+15, t0+19, t0+23; key_down high t0+1 through release+0.
REQ-033 SHALL cover: in WAIT2, flag_press in the same cycle cnt==5 -> PRESS2 entered, no short_click.
REQ-034 SHALL cover: rst_n pulled low mid-WAIT2 -> outputs 0 immediately, no short_click after release of reset.
REQ-035 SHALL cover: flag_press and flag_release together in IDLE -> state stays IDLE, key_down stays 0.
